alu_control_mc: RTL and testbench

ALU_CONTROL_MC -- requirements
Module: alu_control_mc

---
 rtl/alu_control_mc_if.sv | 26 ++
 rtl/alu_control_mc.sv | 142 ++++++++++++++
 tb/tb_alu_control_mc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_mc_if.sv
// Request/response bundle between the main decoder and the ALU-control block,
// plus the side-band signals that launch the multiply/divide datapath.
interface alu_control_mc_if #(
  parameter int CTL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [CTL_W-1:0] aluctl;
  logic             md_start;
  logic [1:0]       md_op;
  logic             busy;

  modport master (
    output in_valid, aluop, funct, out_ready,
    input  in_ready, out_valid, aluctl, md_start, md_op, busy
  );

  modport slave (
    input  in_valid, aluop, funct, out_ready,
    output in_ready, out_valid, aluctl, md_start, md_op, busy
  );
endinterface

// File: rtl/alu_control_mc.sv
// ALU control decoder with valid/ready handshake; mult/div ops are sequenced
// over MD_CYCLES cycles and complete with the HI/LO writeback code.
module alu_control_mc #(
  parameter int CTL_W     = 4,
  parameter int MD_CYCLES = 32
) (
  input logic                clk,
  input logic                rst_n,
  alu_control_mc_if.slave    bus
);
  localparam int               CNT_W    = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [3:0]       CTL_HILO = 4'd8;

  typedef enum logic [1:0] {IDLE, MD_RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CTL_W-1:0] aluctl_q, aluctl_d;
  logic             out_valid_q, out_valid_d;
  logic             md_start_q, md_start_d;
  logic [1:0]       md_op_q, md_op_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             is_md;

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = 4'd0;
    case (op)
      2'b00: code = 4'd2;
      2'b01: code = 4'd6;
      2'b10: begin
        if (fn[5:4] == 2'b10) begin
          case (fn[3:0])
            4'd0:    code = 4'd2;
            4'd2:    code = 4'd6;
            4'd4:    code = 4'd0;
            4'd5:    code = 4'd1;
            4'd6:    code = 4'd13;
            4'd7:    code = 4'd12;
            4'd10:   code = 4'd7;
            4'd11:   code = 4'd15;
            default: code = 4'd0;
          endcase
        end
      end
      default: begin
        case (fn[2:0])
          3'b000:  code = 4'd2;
          3'b010:  code = 4'd7;
          3'b011:  code = 4'd15;
          3'b100:  code = 4'd0;
          3'b101:  code = 4'd1;
          3'b110:  code = 4'd13;
          3'b111:  code = 4'd14;
          default: code = 4'd0;
        endcase
      end
    endcase
    return code;
  endfunction

  // Ready in HOLD only when the held result is drained in the same cycle.
  assign bus.in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_md        = (bus.aluop == 2'b10) && (bus.funct[5:2] == 4'b0110);

  always_comb begin
    // NOTE: every signal gets its default first so no path through this block infers a latch.
    state_d     = state_q;
    aluctl_d    = aluctl_q;
    out_valid_d = out_valid_q;
    md_start_d  = 1'b0;
    md_op_d     = md_op_q;
    busy_d      = busy_q;
    count_d     = count_q;

    case (state_q)
      MD_RUN: begin
        if (count_q == '0) begin
          state_d     = HOLD;
          aluctl_d    = CTL_W'(CTL_HILO);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Acceptance is only possible from IDLE or a draining HOLD, so it overrides both.
    if (accept) begin
      if (is_md) begin
        state_d     = MD_RUN;
        out_valid_d = 1'b0;
        md_start_d  = 1'b1;
        md_op_d     = bus.funct[1:0];
        busy_d      = 1'b1;
        count_d     = CNT_LOAD;
      end else begin
        state_d     = HOLD;
        aluctl_d    = CTL_W'(decode(bus.aluop, bus.funct));
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aluctl_q    <= '0;
      out_valid_q <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= 2'b00;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      aluctl_q    <= aluctl_d;
      out_valid_q <= out_valid_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign bus.aluctl    = aluctl_q;
  assign bus.out_valid = out_valid_q;
  assign bus.md_start  = md_start_q;
  assign bus.md_op     = md_op_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: handshake, mult/div sequencing, reset
// abandonment and a full aluop/funct decode sweep against hand tables.
module tb_alu_control_mc;
  localparam int CTL_W     = 4;
  localparam int MD_CYCLES = 32;

  logic clk;
  logic rst_n;

  alu_control_mc_if #(.CTL_W(CTL_W)) bus ();

  alu_control_mc #(
    .CTL_W    (CTL_W),
    .MD_CYCLES(MD_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // R-type funct[3:0] and I-type funct[2:0] code tables.
  int rtab[16] = '{2, 0, 6, 0, 0, 1, 13, 12, 0, 0, 7, 15, 0, 0, 0, 0};
  int itab[8]  = '{2, 0, 7, 15, 0, 1, 13, 14};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_ctl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 2;
    if (op == 2'b01) return 6;
    if (op == 2'b11) return itab[fn[2:0]];
    if (fn[5:4] == 2'b10) return rtab[fn[3:0]];
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn);
    @(negedge clk);
    bus.aluop    = op;
    bus.funct    = fn;
    bus.in_valid = 1'b1;
    check("accept_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int busy_n;
    int starts;
    int stray;

    bus.in_valid  = 1'b0;
    bus.aluop     = 2'b00;
    bus.funct     = 6'h00;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_aluctl", bus.aluctl, 0);
    check("rst_md_start", bus.md_start, 0);
    check("rst_md_op", bus.md_op, 0);
    check("rst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type sub with consumer always ready.
    bus.out_ready = 1'b1;
    send(2'b10, 6'h22);
    check("sub_valid", bus.out_valid, 1);
    check("sub_aluctl", bus.aluctl, 6);
    check("sub_in_ready", bus.in_ready, 1);
    step();
    check("sub_idle", bus.out_valid, 0);

    // I-type with stalled consumer: result held, no new accepts.
    bus.out_ready = 1'b0;
    send(2'b11, 6'b000101);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("hold_aluctl_%0d", i), bus.aluctl, 1);
      check($sformatf("hold_in_ready_%0d", i), bus.in_ready, 0);
      step();
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    step();
    check("hold_drained", bus.out_valid, 0);

    // div: launch pulse, busy window, ignored requests, HI/LO writeback.
    bus.out_ready = 1'b0;
    send(2'b10, 6'h1A);
    check("md_start", bus.md_start, 1);
    check("md_op", bus.md_op, 2);
    check("md_busy", bus.busy, 1);
    check("md_no_valid", bus.out_valid, 0);
    bus.aluop    = 2'b10;
    bus.funct    = 6'h18;
    bus.in_valid = 1'b1;
    check("md_in_ready", bus.in_ready, 0);
    cyc    = 1;
    busy_n = 0;
    starts = 0;
    while (!bus.out_valid && cyc < 60) begin
      busy_n += int'(bus.busy);
      starts += int'(bus.md_start);
      step();
      cyc++;
    end
    check("md_latency", cyc, MD_CYCLES + 1);
    check("md_busy_cycles", busy_n, MD_CYCLES);
    check("md_start_pulses", starts, 1);
    check("md_aluctl", bus.aluctl, 8);
    check("md_op_stable", bus.md_op, 2);
    check("md_busy_done", bus.busy, 0);
    check("md_hold_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;

    // Back-to-back: drain the div result while accepting a new R-type op.
    bus.out_ready = 1'b1;
    send(2'b10, 6'h27);
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_aluctl", bus.aluctl, 12);
    step();
    check("b2b_idle", bus.out_valid, 0);

    // Reset in the middle of a divu when the counter reaches 10.
    bus.out_ready = 1'b0;
    send(2'b10, 6'h1B);
    repeat (21) step();
    check("mid_busy", bus.busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_aluctl", bus.aluctl, 0);
    check("arst_md_start", bus.md_start, 0);
    check("arst_md_op", bus.md_op, 0);
    check("arst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      step();
      if (bus.out_valid || bus.md_start || bus.busy) stray++;
    end
    check("arst_no_stray", stray, 0);

    // Full decode sweep.
    bus.out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int fn = 0; fn < 64; fn++) begin
        logic [1:0] opv;
        logic [5:0] fnv;
        opv = 2'(op);
        fnv = 6'(fn);
        send(opv, fnv);
        if (opv == 2'b10 && fnv >= 6'd24 && fnv <= 6'd27) begin
          cyc = 1;
          while (!bus.out_valid && cyc < 60) begin
            step();
            cyc++;
          end
          check($sformatf("sweep_md_valid_%0d_%0d", op, fn), bus.out_valid, 1);
          check($sformatf("sweep_md_aluctl_%0d_%0d", op, fn), bus.aluctl, 8);
          check($sformatf("sweep_md_op_%0d_%0d", op, fn), bus.md_op, 32'(fnv[1:0]));
        end else begin
          check($sformatf("sweep_valid_%0d_%0d", op, fn), bus.out_valid, 1);
          check($sformatf("sweep_aluctl_%0d_%0d", op, fn), bus.aluctl, exp_ctl(opv, fnv));
        end
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
